wallace_mult_share_ctrl_4: RTL and testbench
============================================

// Module: wallace_mult_share_ctrl_4
// PURPOSE
//  Shares one combinational 4x4 unsigned Wallace/CLA multiplier (wallace_unsigned_multiplier_CLA_4)
//  between two requesters. Each requester uses a valid/ready handshake.
//  Round-robin arbitration picks a requester; its operands are registered and held for a fixed
//  settle time so the tree resolves, then the registered product is returned with the requester ID.
//  Sits between client logic and the multiplier instance, which has no clock of its own.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles the operands are held at the multiplier before sampling product; legal 1..15
//  OP_W           4  operand width; fixed to 4, the instance width (elaboration error otherwise)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous, active-low reset
//  req0_valid   in   1       requester 0 has operands; a/b stable while valid && !ready
//  req0_a       in   OP_W    requester 0 multiplicand
//  req0_b       in   OP_W    requester 0 multiplier
//  req0_ready   out  1       requester 0 accepted on this edge when valid && ready
//  req1_valid   in   1       requester 1, same as requester 0
//  req1_a       in   OP_W    requester 1 multiplicand
//  req1_b       in   OP_W    requester 1 multiplier
//  req1_ready   out  1       requester 1 accept strobe, same as requester 0
//  rsp_valid    out  1       result available
//  rsp_ready    in   1       consumer takes result when rsp_valid && rsp_ready
//  rsp_id       out  1       requester that issued the result (0/1)
//  rsp_product  out  2*OP_W  unsigned product, registered
//  busy         out  1       high in CALC and RESP
// BEHAVIOUR
//  Reset (rst_n low at an edge, overrides everything):
//   state=IDLE, rr_ptr=0 (req0 favoured); rsp_valid=0, rsp_id=0, rsp_product=0, busy=0;
//   op regs=0. An operation in flight is discarded and produces no response.
//  FSM IDLE -> CALC -> RESP -> IDLE.
//   IDLE: grant is combinational.
//    - If only one valid is high, that requester is granted.
//    - If both are high, the requester named by rr_ptr is granted.
//    - Only the granted requester sees ready=1; both readys are 0 outside IDLE and never high together.
//    - On the accept edge: a/b go into op regs, gnt_id is latched, rr_ptr becomes ~gnt_id,
//      cnt=SETTLE_CYCLES-1, and the FSM goes to CALC.
//   CALC: op regs drive the multiplier.
//    - When cnt==0, the next edge loads rsp_product=mult_out and rsp_id=gnt_id, sets rsp_valid=1,
//      and moves to RESP.
//    - Otherwise cnt decrements.
//   RESP: rsp_valid, rsp_id and rsp_product are held stable until rsp_valid && rsp_ready.
//    - On that edge rsp_valid goes to 0 and the FSM returns to IDLE.
//    - rsp_ready may already be high on the first RESP cycle.
//  Latency: accept at edge k -> rsp_valid high from edge k+SETTLE_CYCLES (S=1: next cycle).
//  Throughput: at best one op per SETTLE_CYCLES+2 cycles. No accept in the cycle RESP completes.
//  Product is exact: 2*OP_W bits, no truncation. Max 15*15=225.
//  A request that drops valid before being accepted is legal and is simply not served.
//  Starvation-free: a waiting requester is served within one foreign op.
// STRUCTURE
//  Shared package/include wallace_ctrl_defs: state encoding IDLE=2'b00, CALC=2'b01, RESP=2'b10;
//  OP_W / PROD_W constants; SETTLE counter width (4).
//  One sub-module is natural: rr_arb2, a 2-way round-robin grant (valid[1:0], ptr -> gnt onehot).
//  The multiplier itself is the existing wallace_unsigned_multiplier_CLA_4 instance.
// TESTING
//  1. Reset hold 3 cycles, then release -> every output 0, busy=0, both readys 0 while no valid.
//  2. req0 a=2 b=3, rsp_ready=1, S=1 -> req0_ready on accept edge; rsp_valid next cycle;
//     product=6, id=0.
//  3. req1 a=10 b=3, then req0 a=13 b=10, serial -> product=30 id=1, then product=130 id=0.
//  4. Both valid from reset, req0 a=15 b=15, req1 a=0 b=9, each re-asserted after acceptance ->
//     order id 0 (225), id 1 (0), id 0 (225): alternates.
//  5. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> product/id stable, readys 0, busy 1;
//     completes on rsp_ready.
//  6. rst_n low during CALC (S=4, a=7 b=9) -> next edge IDLE, rsp_valid never rises.
//     Following op 7*9 -> 63.

Source files
------------

// File: rtl/wallace_mult_share_ctrl_4_pkg.sv
// wallace_mult_share_ctrl_4_pkg: shared types, widths and adder helpers for the shared multiplier controller
package wallace_mult_share_ctrl_4_pkg;
    localparam int DEF_OP_W = 4;
    localparam int PROD_W = 2 * DEF_OP_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef struct packed {
        state_t state;
        logic rr_ptr;
        logic [DEF_OP_W-1:0] op_a;
        logic [DEF_OP_W-1:0] op_b;
        logic gnt_id;
        logic [CNT_W-1:0] cnt;
        logic rsp_valid;
        logic rsp_id;
        logic [PROD_W-1:0] rsp_product;
    } ctrl_regs_t;

    function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x, y, z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x, y, z);
        return {(x[PROD_W-2:0] & y[PROD_W-2:0]) | (x[PROD_W-2:0] & z[PROD_W-2:0]) |
                (y[PROD_W-2:0] & z[PROD_W-2:0]), 1'b0};
    endfunction

    // 4-bit lookahead block: returns {carry_out, sum}
    function automatic logic [4:0] cla4(input logic [3:0] x, y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g = x & y;
        p = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
               ((&p) & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction
endpackage

// File: rtl/wallace_mult_share_ctrl_4_if.sv
// wallace_mult_share_ctrl_4_if: two requester handshakes plus the response channel of the shared multiplier
interface wallace_mult_share_ctrl_4_if;
    import wallace_mult_share_ctrl_4_pkg::*;
    logic req0_valid;
    logic [DEF_OP_W-1:0] req0_a;
    logic [DEF_OP_W-1:0] req0_b;
    logic req0_ready;
    logic req1_valid;
    logic [DEF_OP_W-1:0] req1_a;
    logic [DEF_OP_W-1:0] req1_b;
    logic req1_ready;
    logic rsp_valid;
    logic rsp_ready;
    logic rsp_id;
    logic [PROD_W-1:0] rsp_product;
    logic busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
    );

    modport slave (
        input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
    );
endinterface

// File: rtl/wallace_mult_share_ctrl_4_rr_arb2.sv
// rr_arb2: two-way round-robin grant; ptr names the requester favoured when both are valid
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] gnt
);
    assign gnt[0] = valid[0] & (~valid[1] | ~ptr);
    assign gnt[1] = valid[1] & (~valid[0] | ptr);
endmodule

// File: rtl/wallace_unsigned_multiplier_CLA_4.sv
// wallace_unsigned_multiplier_CLA_4: combinational 4x4 unsigned multiplier, carry-save tree plus lookahead final add
module wallace_unsigned_multiplier_CLA_4
    import wallace_mult_share_ctrl_4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] pp [4];
    logic [7:0] s1, c1, s2, c2;
    logic [4:0] lo, hi;
    logic unused_co;

    for (genvar i = 0; i < 4; i++) begin : g_pp
        assign pp[i] = {4'b0, a & {4{b[i]}}} << i;
    end

    // The product never exceeds 225, so carries past bit 7 are always zero
    assign s1 = csa_sum(pp[0], pp[1], pp[2]);
    assign c1 = csa_carry(pp[0], pp[1], pp[2]);
    assign s2 = csa_sum(s1, c1, pp[3]);
    assign c2 = csa_carry(s1, c1, pp[3]);
    assign lo = cla4(s2[3:0], c2[3:0], 1'b0);
    assign hi = cla4(s2[7:4], c2[7:4], lo[4]);
    assign {unused_co, p[7:4]} = hi;
    assign p[3:0] = lo[3:0];
endmodule

// File: rtl/wallace_mult_share_ctrl_4.sv
// wallace_mult_share_ctrl_4: round-robin sharing of one combinational 4x4 multiplier between two requesters
module wallace_mult_share_ctrl_4
    import wallace_mult_share_ctrl_4_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int OP_W = DEF_OP_W
) (
    input logic clk,
    input logic rst_n,
    wallace_mult_share_ctrl_4_if.slave bus
);
    if (OP_W != DEF_OP_W || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_param
        $error("wallace_mult_share_ctrl_4: OP_W must be 4 and SETTLE_CYCLES 1..15");
    end

    ctrl_regs_t r, r_n;
    logic [1:0] gnt;
    logic [PROD_W-1:0] mult_out;
    logic idle;

    assign idle = r.state == IDLE;

    rr_arb2 u_arb (
        .valid({bus.req1_valid, bus.req0_valid}),
        .ptr(r.rr_ptr),
        .gnt(gnt)
    );

    wallace_unsigned_multiplier_CLA_4 u_mult (
        .a(r.op_a),
        .b(r.op_b),
        .p(mult_out)
    );

    always_ff @(posedge clk) begin
        r <= !rst_n ? '0 : r_n;
    end

    always_comb begin
        r_n = r;
        case (r.state)
            IDLE: if (|gnt) begin
                r_n.state = CALC;
                r_n.op_a = gnt[1] ? bus.req1_a : bus.req0_a;
                r_n.op_b = gnt[1] ? bus.req1_b : bus.req0_b;
                r_n.gnt_id = gnt[1];
                r_n.rr_ptr = ~gnt[1];
                r_n.cnt = CNT_W'(SETTLE_CYCLES - 1);
            end
            CALC: if (r.cnt == '0) begin
                r_n.state = RESP;
                r_n.rsp_product = mult_out;
                r_n.rsp_id = r.gnt_id;
                r_n.rsp_valid = 1'b1;
            end else begin
                r_n.cnt = r.cnt - 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                r_n.state = IDLE;
                r_n.rsp_valid = 1'b0;
            end
            default: r_n.state = IDLE;
        endcase
    end

    assign bus.req0_ready = idle & gnt[0];
    assign bus.req1_ready = idle & gnt[1];
    assign bus.rsp_valid = r.rsp_valid;
    assign bus.rsp_id = r.rsp_id;
    assign bus.rsp_product = r.rsp_product;
    assign bus.busy = ~idle;
endmodule

// File: tb/tb_wallace_mult_share_ctrl_4.sv
// tb_wallace_mult_share_ctrl_4: directed scoreboard bench for the shared multiplier controller (S=1 and S=4 instances)
module tb_wallace_mult_share_ctrl_4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wallace_mult_share_ctrl_4_if b1();
    wallace_mult_share_ctrl_4_if b4();

    wallace_mult_share_ctrl_4 #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    wallace_mult_share_ctrl_4 #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct {
        logic id;
        logic [7:0] prod;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit d, input bit rq, input bit v, input logic [3:0] a, input logic [3:0] b);
        case ({d, rq})
            2'b00: begin b1.req0_valid = v; b1.req0_a = a; b1.req0_b = b; end
            2'b01: begin b1.req1_valid = v; b1.req1_a = a; b1.req1_b = b; end
            2'b10: begin b4.req0_valid = v; b4.req0_a = a; b4.req0_b = b; end
            default: begin b4.req1_valid = v; b4.req1_a = a; b4.req1_b = b; end
        endcase
    endtask

    function automatic logic rdy(input bit d, input bit rq);
        return d ? (rq ? b4.req1_ready : b4.req0_ready) : (rq ? b1.req1_ready : b1.req0_ready);
    endfunction

    // Waits for the grant, records the hand-computed result, then lets go after the accept edge
    task automatic serve(input bit d, input bit rq, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] prod);
        drive(d, rq, 1'b1, a, b);
        #1;
        for (int i = 0; i < 100 && !rdy(d, rq); i++) step();
        chk("accept_ready", 32'(rdy(d, rq)), 32'd1);
        if (rdy(d, rq)) begin
            if (d) q4.push_back('{id: rq, prod: prod});
            else q1.push_back('{id: rq, prod: prod});
        end
        step();
        drive(d, rq, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (b1.busy || b4.busy || q1.size() != 0 || q4.size() != 0); i++) step();
        chk("drain_busy", 32'(b1.busy | b4.busy), 32'd0);
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && b1.rsp_valid && b1.rsp_ready) begin
            if (q1.size() == 0) chk("s1_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("s1_rsp_id", 32'(b1.rsp_id), 32'(e.id));
                chk("s1_rsp_product", 32'(b1.rsp_product), 32'(e.prod));
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n && b4.rsp_valid && b4.rsp_ready) begin
            if (q4.size() == 0) chk("s4_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                chk("s4_rsp_id", 32'(b4.rsp_id), 32'(e.id));
                chk("s4_rsp_product", 32'(b4.rsp_product), 32'(e.prod));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) for (int rq = 0; rq < 2; rq++) drive(d[0], rq[0], 1'b0, 4'd0, 4'd0);
        b1.rsp_ready = 1'b0;
        b4.rsp_ready = 1'b0;

        // reset and idle outputs
        reset_all();
        chk("t1_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("t1_rsp_id", 32'(b1.rsp_id), 32'd0);
        chk("t1_rsp_product", 32'(b1.rsp_product), 32'd0);
        chk("t1_busy", 32'(b1.busy), 32'd0);
        chk("t1_ready0", 32'(b1.req0_ready), 32'd0);
        chk("t1_ready1", 32'(b1.req1_ready), 32'd0);
        chk("t1_s4_busy", 32'(b4.busy), 32'd0);
        chk("t1_s4_rsp_valid", 32'(b4.rsp_valid), 32'd0);
        step();
        chk("t1_busy_after", 32'(b1.busy), 32'd0);

        // single op, S=1 latency
        b1.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 4'd2, 4'd3);
        #1;
        chk("t2_req0_ready", 32'(b1.req0_ready), 32'd1);
        chk("t2_req1_ready", 32'(b1.req1_ready), 32'd0);
        q1.push_back('{id: 1'b0, prod: 8'd6});
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("t2_calc_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("t2_calc_busy", 32'(b1.busy), 32'd1);
        chk("t2_calc_ready0", 32'(b1.req0_ready), 32'd0);
        step();
        chk("t2_resp_valid", 32'(b1.rsp_valid), 32'd1);
        step();
        chk("t2_done_valid", 32'(b1.rsp_valid), 32'd0);
        chk("t2_done_busy", 32'(b1.busy), 32'd0);

        // serial ops from both requesters
        serve(1'b0, 1'b1, 4'd10, 4'd3, 8'd30);
        serve(1'b0, 1'b0, 4'd13, 4'd10, 8'd130);
        wait_idle();

        // both valid from reset: grants alternate starting at req0
        reset_all();
        q1.push_back('{id: 1'b0, prod: 8'd225});
        q1.push_back('{id: 1'b1, prod: 8'd0});
        q1.push_back('{id: 1'b0, prod: 8'd225});
        drive(1'b0, 1'b0, 1'b1, 4'd15, 4'd15);
        drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd9);
        #1;
        n = 0;
        for (int i = 0; i < 100 && n < 3; i++) begin
            chk("t4_ready_exclusive", 32'(b1.req0_ready & b1.req1_ready), 32'd0);
            if (b1.req0_ready || b1.req1_ready) n++;
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("t4_accepts", 32'(n), 32'd3);
        wait_idle();

        // backpressure holds the response
        b1.rsp_ready = 1'b0;
        serve(1'b0, 1'b1, 4'd5, 4'd6, 8'd30);
        for (int i = 0; i < 20 && !b1.rsp_valid; i++) step();
        drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd1);
        #1;
        repeat (5) begin
            chk("t5_hold_valid", 32'(b1.rsp_valid), 32'd1);
            chk("t5_hold_product", 32'(b1.rsp_product), 32'd30);
            chk("t5_hold_id", 32'(b1.rsp_id), 32'd1);
            chk("t5_hold_ready0", 32'(b1.req0_ready), 32'd0);
            chk("t5_hold_busy", 32'(b1.busy), 32'd1);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        b1.rsp_ready = 1'b1;
        wait_idle();

        // reset during CALC on the S=4 instance discards the op
        b4.rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 4'd7, 4'd9);
        #1;
        chk("t6_ready0", 32'(b4.req0_ready), 32'd1);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        chk("t6_calc_busy", 32'(b4.busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_reset_busy", 32'(b4.busy), 32'd0);
        repeat (8) begin
            chk("t6_no_rsp", 32'(b4.rsp_valid), 32'd0);
            step();
        end
        serve(1'b1, 1'b0, 4'd7, 4'd9, 8'd63);
        n = 0;
        for (int i = 0; i < 10 && !b4.rsp_valid; i++) begin
            step();
            n++;
        end
        chk("t6_latency", 32'(n), 32'd4);
        wait_idle();

        chk("end_q1_empty", 32'(q1.size()), 32'd0);
        chk("end_q4_empty", 32'(q4.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
